// File: rtl/trig_pkg.sv
// Shared types and constants for the trig lookup scheduler.
// Angles are unsigned degrees; the sine unit sees 1..360 only.
package trig_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SIN,
    COS,
    RESP
  } state_t;

  localparam int PI_BY_2        = 90;
  localparam int FULL_TURN      = 360;
  localparam int LUT_IDLE_ANGLE = 90;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/trig_lookup_sched.sv
// Shares one sine lookup between N_REQ requesters: sin(a) then
// sin(a+90) per grant, returned over a valid/ready response.
module trig_lookup_sched #(
  parameter int N_REQ = 3,
  parameter int ANG_W = 16,
  parameter int VAL_W = 16,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*ANG_W-1:0] req_angle,
  output logic [N_REQ-1:0]       ack,
  output logic [ANG_W-1:0]       lut_angle,
  input  logic [VAL_W-1:0]       lut_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [VAL_W-1:0]       sin_val,
  output logic [VAL_W-1:0]       cos_val
);
  import trig_pkg::*;

  localparam logic [ANG_W-1:0] TURN     = ANG_W'(FULL_TURN);
  localparam logic [ANG_W:0]   TURN_X   = (ANG_W+1)'(FULL_TURN);
  localparam logic [ANG_W:0]   QUART_X  = (ANG_W+1)'(PI_BY_2);
  localparam logic [ANG_W-1:0] IDLE_ANG = ANG_W'(LUT_IDLE_ANGLE);
  localparam logic [ID_W-1:0]  LAST     = ID_W'(N_REQ-1);

  state_t           state;
  state_t           state_nx;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  id_r;
  logic [ANG_W-1:0] angle_r;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  idx;
  logic             any;
  logic [ANG_W-1:0] ang_in;
  logic [ANG_W-1:0] ang_cap;
  logic [ANG_W:0]   cos_sum;
  logic [ANG_W-1:0] cos_ang;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req(req),
    .ptr(ptr),
    .gnt(gnt),
    .idx(idx),
    .any(any)
  );

  // Zero is fed to the ROM as 360 so it never sees address 0.
  function automatic logic [ANG_W-1:0] map_ang(
    input logic [ANG_W-1:0] x
  );
    return (x == '0) ? TURN : x;
  endfunction

  assign ang_in  = req_angle[int'(idx)*ANG_W +: ANG_W];
  assign ang_cap = (ang_in >= TURN) ? ang_in - TURN : ang_in;
  assign cos_sum = {1'b0, angle_r} + QUART_X;
  assign cos_ang = ANG_W'((cos_sum >= TURN_X) ?
                          cos_sum - TURN_X : cos_sum);

  assign rsp_valid = (state == RESP);
  assign rsp_id    = id_r;

  always_comb begin
    state_nx  = state;
    lut_angle = IDLE_ANG;
    ack       = '0;
    unique case (state)
      IDLE: begin
        if (any) begin
          ack      = gnt & {N_REQ{rst_n}};
          state_nx = SIN;
        end
      end
      SIN: begin
        lut_angle = map_ang(angle_r);
        state_nx  = COS;
      end
      COS: begin
        lut_angle = map_ang(cos_ang);
        state_nx  = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      id_r    <= '0;
      angle_r <= '0;
      sin_val <= '0;
      cos_val <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && any) begin
        angle_r <= ang_cap;
        id_r    <= idx;
        ptr     <= (idx == LAST) ? '0 : idx + ID_W'(1);
      end
      if (state == SIN) sin_val <= lut_data;
      if (state == COS) cos_val <= lut_data;
    end
  end

endmodule
